// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the gpio block.
//   Register offsets relative to BASE_ADDR, register count and CSR bus widths.
package gpio_pkg;

  localparam int unsigned CSR_AW = 5;
  localparam int unsigned CSR_DW = 8;
  localparam int unsigned MAX_GPIOS = 8;

  // Register offsets from the instance base address
  localparam int unsigned REG_DIR = 0;
  localparam int unsigned REG_OUT = 1;
  localparam int unsigned REG_IN  = 2;
  localparam int unsigned REG_IE  = 3;
  localparam int unsigned REG_IP  = 4;
  localparam int unsigned REG_IEV = 5;
  localparam int unsigned NUM_REGS = 6;

  // Offset of csr_a from base; only meaningful when addr_hit() is true
  function automatic logic [CSR_AW-1:0] addr_offset(input logic [CSR_AW-1:0] a,
                                                    input logic [CSR_AW-1:0] base);
    return a - base;
  endfunction

  // True when csr_a falls inside base .. base+NUM_REGS-1
  function automatic logic addr_hit(input logic [CSR_AW-1:0] a,
                                    input logic [CSR_AW-1:0] base);
    logic [CSR_AW-1:0] off;
    off = a - base;
    return (a >= base) && (off < CSR_AW'(NUM_REGS));
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: WIDTH-bit, STAGES-deep flop chain bringing asynchronous pad
// inputs into the clk domain.
//   clk, rst : clock, asynchronous active-high reset (chain clears to 0)
//   d        : asynchronous input
//   q        : last synchroniser stage
module gpio_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;

  // Shift chain: stage 0 captures the pad, stage STAGES-1 is the safe output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/gpio.sv
// gpio: bidirectional GPIO port on the 8-bit CSR bus.
//   Registers (offset from BASE_ADDR): DIR, OUT, IN (RO), IE, IP (RW1C), IEV.
//   clk, rst  : clock, asynchronous active-high reset
//   csr_a     : CSR address;  csr_di : write data;  csr_we : write strobe
//   csr_do    : registered read data (1-cycle latency, 0 outside the map)
//   gpio_in   : asynchronous pad input
//   gpio_out  : pad output data;  gpio_oe : pad output enable (1 = drive)
//   irq       : level interrupt, OR of enabled pending bits
module gpio
  import gpio_pkg::*;
#(
  parameter logic [4:0]  BASE_ADDR   = 5'h0,
  parameter int unsigned NUM_GPIOS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           csr_a,
  input  logic [7:0]           csr_di,
  input  logic                 csr_we,
  output logic [7:0]           csr_do,
  input  logic [NUM_GPIOS-1:0] gpio_in,
  output logic [NUM_GPIOS-1:0] gpio_out,
  output logic [NUM_GPIOS-1:0] gpio_oe,
  output logic                 irq
);

  localparam int unsigned N = NUM_GPIOS;

  logic [N-1:0] dir_q;
  logic [N-1:0] out_q;
  logic [N-1:0] ie_q;
  logic [N-1:0] ip_q;
  logic [N-1:0] iev_q;
  logic [N-1:0] prev_q;
  logic [N-1:0] in_s;

  logic [N-1:0] wdata;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] ev;
  logic [N-1:0] clr;

  logic         hit;
  logic [4:0]   offset;
  logic         we_dir;
  logic         we_out;
  logic         we_ie;
  logic         we_ip;
  logic         we_iev;
  logic [7:0]   rdata;

  // Pad input synchroniser
  gpio_sync #(
    .WIDTH  (N),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_in),
    .q   (in_s)
  );

  // Address decode and write strobes; bits at NUM_GPIOS and above are dropped
  always_comb begin
    hit    = addr_hit(csr_a, BASE_ADDR);
    offset = addr_offset(csr_a, BASE_ADDR);
    wdata  = csr_di[N-1:0];
    we_dir = 1'b0;
    we_out = 1'b0;
    we_ie  = 1'b0;
    we_ip  = 1'b0;
    we_iev = 1'b0;
    if (csr_we && hit) begin
      we_dir = (offset == 5'(REG_DIR));
      we_out = (offset == 5'(REG_OUT));
      we_ie  = (offset == 5'(REG_IE));
      we_ip  = (offset == 5'(REG_IP));
      we_iev = (offset == 5'(REG_IEV));
    end
  end

  // Edge detect on the synchronised input, selected per pin by IEV
  always_comb begin
    rise = in_s & ~prev_q;
    fall = ~in_s & prev_q;
    ev   = (iev_q & fall) | (~iev_q & rise);
    clr  = we_ip ? wdata : '0;
  end

  // Read mux: pins zero-extended to the bus width, unmapped reads return 0
  always_comb begin
    rdata = 8'h00;
    if (hit) begin
      case (offset)
        5'(REG_DIR): rdata = 8'(dir_q);
        5'(REG_OUT): rdata = 8'(out_q);
        5'(REG_IN):  rdata = 8'(in_s);
        5'(REG_IE):  rdata = 8'(ie_q);
        5'(REG_IP):  rdata = 8'(ip_q);
        5'(REG_IEV): rdata = 8'(iev_q);
        default:     rdata = 8'h00;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q <= '0;
      out_q <= '0;
      ie_q  <= '0;
      iev_q <= '0;
    end else begin
      if (we_dir) dir_q <= wdata;
      if (we_out) out_q <= wdata;
      if (we_ie)  ie_q  <= wdata;
      if (we_iev) iev_q <= wdata;
    end
  end

  // Sticky pending bits: a new event in the clearing cycle survives the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip_q   <= '0;
      prev_q <= '0;
    end else begin
      ip_q   <= (ip_q & ~clr) | ev;
      prev_q <= in_s;
    end
  end

  // Registered read data; sampled before any same-cycle write lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_do <= 8'h00;
    end else begin
      csr_do <= rdata;
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  // Pure OR of flops, so no combinational path from the pads
  assign irq      = |(ip_q & ie_q);

endmodule

// File: doc/gpio.md
# gpio

Parametrised general-purpose I/O block on the 8-bit CSR bus, the bidirectional successor to the output-only port. It provides per-pin output enable and output data, and synchronised input sampling. Per-pin edge detection sets sticky pending bits that can be masked and cleared; the unmasked pending bits are ORed into one interrupt line for the interrupt controller. Up to eight pins per instance; several instances sit at distinct CSR bases.

## Interface
- BASE_ADDR, 5'h0: CSR offset of the first register; BASE_ADDR+5 must be ≤ 5'h1f.
- NUM_GPIOS, 8: pin count, 1..8.
- SYNC_STAGES, 2: input synchroniser depth, ≥ 2.
- clk  in  1  single clock; every flop is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- csr_a  in  5  CSR address.
- csr_di  in  8  CSR write data.
- csr_we  in  1  CSR write strobe, one cycle per write.
- csr_do  out  8  registered CSR read data.
- gpio_in  in  NUM_GPIOS  pad input, asynchronous to clk.
- gpio_out  out  NUM_GPIOS  pad output data.
- gpio_oe  out  NUM_GPIOS  pad output enable, 1 = drive.
- irq  out  1  level interrupt, active-high.

## Operation
- Register map is offset from BASE_ADDR. Bits at NUM_GPIOS and above read 0 and ignore writes.
  - +0 DIR, RW: drives gpio_oe.
  - +1 OUT, RW: drives gpio_out. It holds its value while DIR=0.
  - +2 IN, RO: last synchroniser stage. Writes are ignored.
  - +3 IE, RW: interrupt enable per pin.
  - +4 IP, RW1C: sticky edge pending per pin.
  - +5 IEV, RW: edge select per pin, 0 = rising, 1 = falling.
- Reset values:
  - DIR, OUT, IE, IP and IEV are 0.
  - The synchroniser chain and the previous-value register are 0.
  - csr_do = 0, gpio_out = 0, gpio_oe = 0, irq = 0.
- Edge detection:
  - prev is the last synchroniser stage delayed by one clock.
  - rise = s & ~prev; fall = ~s & prev.
  - ev = IEV ? fall : rise, evaluated per pin.
- IP update each cycle: IP <= (IP & ~clr) | ev.
  - clr = csr_di when IP is written, otherwise 0.
  - A set and a clear on the same pin in the same cycle leaves IP = 1: set wins.
- Edges are detected on every pin regardless of DIR. An output pin therefore reflects its own pad through IN and IP.
- IE masks irq only. IP sets even when IE = 0.
- Writing IEV does not clear IP. A change of IEV alone never creates an event.
- irq = |(IP & IE). It is a combinational OR of flops only, with no path from gpio_in.
- Reads have no side effects. An address outside BASE..BASE+5 returns 0.
- A write to a read-only register or to an unmapped address is a no-op.
- Asserting rst mid-operation returns every flop to its reset value immediately. Pending events are lost.

## Timing
- Write: with csr_we high at edge N, the register holds the new value after edge N. gpio_out and gpio_oe change in the same cycle.
- Read: csr_a is sampled at edge N and csr_do is valid after edge N, giving 1-cycle latency.
  - A read and a write to the same register in the same cycle returns the old value.
- Input path: a pad change captured at edge k appears in IN, readable at csr_do one cycle later, after edge k+SYNC_STAGES-1.
- Interrupt path: the IP bit sets at edge k+SYNC_STAGES, and irq rises in the same cycle if IE = 1.
- Pulses shorter than one clock period may be missed. An edge pair inside one period produces no event.
- Clearing the last enabled pending bit at edge N drops irq after edge N.

## Structure
- Package gpio_pkg holds the register offset constants REG_DIR … REG_IEV (0..5) and the register count.
- Sub-module gpio_sync:
  - an N-bit, SYNC_STAGES-deep synchroniser with asynchronous reset to 0;
  - one instance per gpio block.
- The remainder is one module: the register file, edge detect, read mux and irq.

## Test plan
- Reset: assert rst asynchronously mid-cycle. Every output is 0 immediately, and reads of +0..+5 return 8'h00 after release.
- Output: write DIR=8'hA5, then OUT=8'h3C. gpio_oe = A5 and gpio_out = 3C one cycle after each write, and reads return A5 and 3C.
- Input latency: with gpio_in = 8'h81, IN reads 8'h81 exactly SYNC_STAGES+1 cycles after the pad change, and never earlier.
- Interrupts:
  - Setup: IE = 8'h03, IEV = 8'h02; raise pin 0 and pin 1 together, then lower both.
  - IP = 8'h01 after the rise, and irq is high.
  - After the fall IP = 8'h03.
  - Writing IP = 8'h01 leaves 8'h02, and irq stays high.
- Clear versus set: write IP = 8'h01 on the exact cycle pin 0 raises a new rising event. IP bit 0 stays 1.
- Parameters: instance with NUM_GPIOS=3, BASE_ADDR=5'h1a.
  - Writing 8'hFF to +0 reads back 8'h07.
  - Address 5'h19 reads 0.
  - A write to 5'h19 leaves every register unchanged.
